// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_e : receive FSM state encoding (IDLE, DATA, PARITY, STOP)
//   - PS2_PFX_EXT / PS2_PFX_BRK : prefix bytes folded into flag bits
//   - KD_BRK / KD_EXT : flag bit positions inside key_data
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int KD_BRK = 8;
  localparam int KD_EXT = 9;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous show-ahead FIFO.
//   clk, rstn   : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full unless popping the same cycle)
//   push_data   : W-bit entry
//   pop         : remove head entry (ignored when empty)
//   full, empty : occupancy flags
//   rd_data     : head entry, all zeros when empty
// DEPTH must be a power of two so the pointers wrap naturally.
module kbd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // A pop on a full FIFO frees the slot the same-cycle push writes into.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard front end for the terminal/keyboard port.
// Deserialises device-to-host frames (start, d[7:0] LSB first, odd parity,
// stop), folds E0/F0 prefixes into flag bits and queues codes in a FIFO.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   ps2_clk    : PS/2 clock pin (asynchronous)
//   ps2_data   : PS/2 data pin (asynchronous)
//   key_en     : pop strobe
//   key_data   : FIFO head {6'b0, ext, brk, scan code}, 0 when empty
//   key_av     : FIFO non-empty
//   key_ovf    : sticky, a code was dropped on a full FIFO
//   dbg_state  : current receive FSM state
// Build option: define PS2_PARITY_CHECK_EN to also reject frames whose
// parity is not odd; otherwise only the stop bit decides acceptance.
//
// Handshake: key_av is "valid", key_en is "ready"; an entry transfers on
// every clk edge where both are 1, with key_data sampled on that same edge.
// key_en while key_av=0 has no effect.
module ps2_kbd_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        key_en,
  output logic [15:0] key_data,
  output logic        key_av,
  output logic        key_ovf,
  output logic [1:0]  dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
`else
  localparam bit PAR_CHECK = 1'b0;
`endif

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  ps2_state_e state, state_nxt;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            ext_flag, brk_flag;

  logic        par_odd;
  logic        accept;
  logic        is_ext, is_brk;
  logic        push_req, push, pop;
  logic        ovf_set;
  logic        fifo_full, fifo_empty;
  logic [15:0] push_data;

  // Synchronisers idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // The timeout only fires on a cycle without a fall, so a fall always wins.
  assign timeout = (state != IDLE) && !fall &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall && !dat_s2)          state_nxt = DATA;
        DATA:    if (fall && bitcnt == 3'd7)   state_nxt = PARITY;
        PARITY:  if (fall)                     state_nxt = STOP;
        STOP:    if (fall)                     state_nxt = IDLE;
        default:                               state_nxt = IDLE;
      endcase
    end
  end

  // Frame evaluation happens on the fall that carries the stop bit.
  assign par_odd  = ^{shreg, par_bit};
  assign accept   = (state == STOP) && fall && dat_s2 && (par_odd || !PAR_CHECK);
  assign is_ext   = (shreg == PS2_PFX_EXT);
  assign is_brk   = (shreg == PS2_PFX_BRK);
  assign push_req = accept && !is_ext && !is_brk;
  assign pop      = key_en && key_av;
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;

  always_comb begin
    push_data         = '0;
    push_data[7:0]    = shreg;
    push_data[KD_BRK] = brk_flag;
    push_data[KD_EXT] = ext_flag;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      key_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state == IDLE && fall && !dat_s2) begin
        bitcnt <= '0;
      end else if (state == DATA && fall) begin
        bitcnt <= bitcnt + 1'b1;
      end

      if (state == DATA && fall) begin
        shreg <= {dat_s2, shreg[7:1]};
      end

      if (state == PARITY && fall) begin
        par_bit <= dat_s2;
      end

      // Flags survive timeouts and rejected frames; any pushed or dropped
      // code consumes them.
      if (accept) begin
        if (is_ext) begin
          ext_flag <= 1'b1;
        end else if (is_brk) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end

      if (ovf_set) begin
        key_ovf <= 1'b1;
      end
    end
  end

  kbd_fifo #(
    .W     (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .rd_data   (key_data)
  );

  assign key_av    = ~fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: self-checking bench for ps2_kbd_rx with a scoreboard of
// expected FIFO entries built from a small reference model of the
// prefix/parity/overflow rules.
module tb_ps2_kbd_rx;
  import ps2_kbd_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        key_en = 1'b0;
  logic [15:0] key_data;
  logic        key_av;
  logic        key_ovf;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_en    (key_en),
    .key_data  (key_data),
    .key_av    (key_av),
    .key_ovf   (key_ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [15:0] exp_q[$];
  bit          m_ext, m_brk, m_ovf;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [1:0]  st_idle;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      tick(4);
      ps2_clk = 1'b0;
      tick(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_code(input logic [7:0] b, input bit bad_par);
    bit ok;
    send_bits(make_frame(b, bad_par), 11);
    tick(10);
    ok = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    if (bad_par) ok = 1'b0;
`endif
    if (ok) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (exp_q.size() < DEPTH) exp_q.push_back({6'b0, m_ext, m_brk, b});
        else m_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic pop_one(output logic av, output logic [15:0] d);
    av = key_av;
    d  = key_data;
    key_en = 1'b1;
    tick(1);
    key_en = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    tick(3);
    n_checks++; if (key_data !== 16'h0000) $display("FAIL reset_data got=%h exp=0000", key_data); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL reset_av got=%b exp=0", key_av); else n_pass++;
    n_checks++; if (key_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", key_ovf); else n_pass++;
    n_checks++; if (dbg_state !== st_idle) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, st_idle); else n_pass++;
    rstn = 1'b1;
    tick(2);
  endtask

  task automatic test_make();
    logic av; logic [15:0] d, e;
    send_code(8'h1C, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1) $display("FAIL make_av got=%b exp=1", av); else n_pass++;
    n_checks++; if (d !== e) $display("FAIL make_data got=%h exp=%h", d, e); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL make_empty_av got=%b exp=0", key_av); else n_pass++;
    n_checks++; if (key_data !== 16'h0000) $display("FAIL make_empty_data got=%h exp=0000", key_data); else n_pass++;
  endtask

  task automatic test_prefix();
    logic av; logic [15:0] d, e;
    send_code(8'hE0, 1'b0);
    send_code(8'hF0, 1'b0);
    send_code(8'h75, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL prefix_ext_brk got=%b/%h exp=1/%h", av, d, e); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL prefix_single got=%b exp=0", key_av); else n_pass++;
    send_code(8'h75, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL prefix_cleared got=%b/%h exp=1/%h", av, d, e); else n_pass++;
  endtask

  task automatic test_parity();
    logic av; logic [15:0] d, e;
    logic exp_av;
    send_code(8'h1C, 1'b1);
    exp_av = (exp_q.size() != 0);
    n_checks++; if (key_av !== exp_av) $display("FAIL parity_av got=%b exp=%b", key_av, exp_av); else n_pass++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(av, d);
      n_checks++; if (d !== e) $display("FAIL parity_data got=%h exp=%h", d, e); else n_pass++;
    end
    n_checks++; if (key_av !== 1'b0) $display("FAIL parity_drain got=%b exp=0", key_av); else n_pass++;
  endtask

  task automatic test_overflow();
    logic av; logic [15:0] d, e;
    for (int i = 1; i <= 17; i++) send_code(8'(i), 1'b0);
    n_checks++; if (key_ovf !== m_ovf) $display("FAIL ovf_flag got=%b exp=%b", key_ovf, m_ovf); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      e = exp_q.pop_front();
      pop_one(av, d);
      n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, av, d, e); else n_pass++;
    end
    n_checks++; if (key_av !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", key_av); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic av; logic [15:0] d, e;
    send_code(8'h11, 1'b0);
    send_code(8'h22, 1'b0);
    key_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 16'h0000;
      n_checks++; if (key_data !== e) $display("FAIL held_en_data%0d got=%h exp=%h", i, key_data, e); else n_pass++;
      n_checks++; if (key_av !== (i < 2)) $display("FAIL held_en_av%0d got=%b exp=%b", i, key_av, (i < 2)); else n_pass++;
      tick(1);
    end
    key_en = 1'b0;
    n_checks++; if (key_av !== 1'b0 || key_data !== 16'h0000) $display("FAIL held_en_end got=%b/%h exp=0/0000", key_av, key_data); else n_pass++;
    send_code(8'h33, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL no_underflow got=%b/%h exp=1/%h", av, d, e); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL no_underflow_empty got=%b exp=0", key_av); else n_pass++;
    n_checks++; if (key_ovf !== m_ovf) $display("FAIL ovf_sticky got=%b exp=%b", key_ovf, m_ovf); else n_pass++;
  endtask

  task automatic test_timeout();
    logic av; logic [15:0] d, e;
    send_bits(make_frame(8'h55, 1'b0), 5);
    tick(TIMEOUT + 20);
    n_checks++; if (dbg_state !== st_idle) $display("FAIL timeout_state got=%0d exp=%0d", dbg_state, st_idle); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL timeout_nopush got=%b exp=0", key_av); else n_pass++;
    send_code(8'h2A, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL timeout_next got=%b/%h exp=1/%h", av, d, e); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL timeout_single got=%b exp=0", key_av); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic av; logic [15:0] d, e;
    send_code(8'hE0, 1'b0);
    send_code(8'h44, 1'b0);
    send_bits(make_frame(8'h29, 1'b0), 5);
    rstn = 1'b0;
    model_reset();
    tick(2);
    n_checks++; if (key_data !== 16'h0000) $display("FAIL midrst_data got=%h exp=0000", key_data); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL midrst_av got=%b exp=0", key_av); else n_pass++;
    n_checks++; if (key_ovf !== 1'b0) $display("FAIL midrst_ovf got=%b exp=0", key_ovf); else n_pass++;
    n_checks++; if (dbg_state !== st_idle) $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, st_idle); else n_pass++;
    rstn = 1'b1;
    tick(2);
    send_code(8'hE0, 1'b0);
    rstn = 1'b0;
    model_reset();
    tick(2);
    rstn = 1'b1;
    tick(2);
    send_code(8'h29, 1'b0);
    e = exp_q.pop_front();
    pop_one(av, d);
    n_checks++; if (av !== 1'b1 || d !== e) $display("FAIL midrst_next got=%b/%h exp=1/%h", av, d, e); else n_pass++;
    n_checks++; if (key_av !== 1'b0) $display("FAIL midrst_single got=%b exp=0", key_av); else n_pass++;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    st_idle = IDLE;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    test_reset();
    test_make();
    test_prefix();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
